motor_balance_ctrl: RTL and testbench
=====================================

// Module: motor_balance_ctrl
// PURPOSE
//  Downstream consumer of the wheel position manager. Samples the signed position difference
//  (pos_diff = wheel1 - wheel2) on a fixed update interval and adjusts a saturating trim term.
//  Splits the trim across the two motor PWM duties so that both wheels track the same distance.
//  Generates both PWM outputs. Issues the clear request that zeroes the position counters
//  when a run starts.
// PARAMETERS
//  PWM_BITS       8       duty / PWM counter width
//  UPDATE_CYCLES  100000  clk cycles between trim updates (>=4)
//  DEADBAND       2       |pos_diff| <= DEADBAND -> trim unchanged
//  TRIM_STEP      1       trim change per update
//  MAX_TRIM       64      trim saturates at +/-MAX_TRIM (< 2^(PWM_BITS-1))
// PORTS
//  clk        in   1         system clock, all logic on posedge
//  reset      in   1         async active-high reset
//  enable     in   1         level; 1 = run balancing, 0 = motors off
//  base_duty  in   PWM_BITS  commanded duty for both wheels
//  pos_diff   in   16        signed two's-complement wheel1 - wheel2 from position manager
//  clear      out  2         to position manager; 2'b11 for exactly one cycle at run start
//  pwm1       out  1         motor 1 PWM
//  pwm2       out  1         motor 2 PWM
//  duty1      out  PWM_BITS  duty currently applied to pwm1
//  duty2      out  PWM_BITS  duty currently applied to pwm2
//  trim       out  8         signed current trim (sign-extended / truncated to 8 bits)
//  update     out  1         one-cycle pulse when trim is re-evaluated
// BEHAVIOUR
//  Reset values: state=IDLE; trim=0; clear=0; pwm1=pwm2=0; duty1=duty2=0; update=0.
//  Reset also zeroes the interval counter and the PWM counter. Reset mid-run aborts immediately.
//  FSM states:
//   IDLE  : outputs off. enable=1 -> CLEAR.
//   CLEAR : clear=2'b11 for this single cycle; trim<=0; interval counter<=0. Next state RUN.
//   RUN   : interval counter increments. At UPDATE_CYCLES-1 -> UPDATE. enable=0 -> IDLE (any cycle).
//   UPDATE: one cycle. update=1. Samples pos_diff as a signed value:
//           pos_diff >  DEADBAND -> trim <= min(trim+TRIM_STEP,  MAX_TRIM)
//           pos_diff < -DEADBAND -> trim <= max(trim-TRIM_STEP, -MAX_TRIM)
//           otherwise trim is held. Counter <= 0. Next state RUN (or IDLE if enable=0).
//  Duty targets: t1 = clamp(base_duty - trim, 0, 2^PWM_BITS-1)
//                t2 = clamp(base_duty + trim, 0, 2^PWM_BITS-1)
//   Arithmetic is done at PWM_BITS+2 signed width. No wrap-around is allowed.
//  PWM: a free-running PWM_BITS counter pc runs while not IDLE.
//   duty1/duty2 load t1/t2 only on the cycle pc wraps to 0, so duty never changes mid-period.
//   The first load occurs in CLEAR.
//   pwm_n = (pc < duty_n), registered, so it lags pc by one cycle.
//   duty=0 -> constant 0; duty=2^PWM_BITS-1 -> low for 1 of 2^PWM_BITS cycles.
//  Leaving RUN/UPDATE for IDLE forces pwm1/pwm2/duty to 0 on the next edge.
//  Trim is retained until the next CLEAR.
//  enable toggling 1->0->1 always produces a fresh CLEAR pulse.
//  base_duty changes take effect at the next PWM wrap; trim is not affected.
//  Trim update latency: pos_diff sampled in UPDATE -> trim visible next cycle
//   -> duty at the following PWM wrap.
// STRUCTURE
//  Shared package motor_pkg: FSM state encoding (IDLE, CLEAR, RUN, UPDATE),
//   CLEAR_ALL = 2'b11 constant, sat/clamp helper function.
//  One sub-module: pwm_gen. Holds the counter, wrap-synchronised duty load and compare.
//   Instantiated twice, with the counter shared via an input, or once per motor.
// TESTING (UPDATE_CYCLES=8, PWM_BITS=8 for sim)
//  Reset asserted mid-RUN with trim=5 -> same cycle async: trim=0, pwm=0, state IDLE.
//   After release, no clear pulse until enable=1.
//  enable 0->1 -> clear==2'b11 exactly one cycle, then 0; trim=0; duty1=duty2=base_duty=128.
//  pos_diff=+10 held for 3 updates -> trim=3; duty1=125, duty2=131 after the next PWM wrap.
//   pwm1 high 125/256 cycles.
//  pos_diff=+2 or -2 (deadband) -> update pulses, trim unchanged. pos_diff=16'hFFF0 (-16) -> trim decrements.
//  Saturation: base_duty=250, pos_diff=-100 for 80 updates -> trim=-64; duty1=255 (clamped), duty2=186.
//   base_duty=10 with trim=+64 -> duty1=0 (pwm1 constant 0).
//  Duty glitch check: change base_duty mid-period -> pwm width for the current period unchanged.
//   New duty at pc==0. enable->0 -> pwm1/pwm2 low next cycle.

Source files
------------

// File: rtl/motor_balance_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pkg
//  Description : Shared types and helpers for the motor balance controller:
//                FSM state encoding, clear-request constant, saturate helper.
//  Revision    : 1.0  initial release
// ============================================================================
package motor_pkg;

    // Controller FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RUN    = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Request pattern that zeroes both position counters
    localparam logic [1:0] c_CLEAR_ALL = 2'b11;

    // Saturate a value into [lo, hi]; used for both trim limits and duty clamping
    function automatic int sat(input int value, input int lo, input int hi);
        int r;
        r = value;
        if (value < lo) begin
            r = lo;
        end else if (value > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_balance_ctrl_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_gen
//  Description : One motor PWM channel. Duty is captured only at the period
//                boundary signalled by i_load, so a period is never cut short
//                or stretched. Output is registered (lags the counter by one).
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_gen
    import motor_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_stop,
    input  logic                i_load,
    input  logic [PWM_BITS-1:0] i_target,
    input  logic [PWM_BITS-1:0] i_pc,
    output logic [PWM_BITS-1:0] o_duty,
    output logic                o_pwm
);

    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;

    // Duty capture at period boundary and registered compare against shared counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else if (i_stop) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (i_load) begin
                r_duty <= i_target;
            end
            r_pwm <= (i_pc < r_duty);
        end
    end

    assign o_duty = r_duty;
    assign o_pwm  = r_pwm;

endmodule
`default_nettype wire

// File: rtl/motor_balance_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : motor_balance_ctrl
//  Description : Periodically samples the wheel position difference, steers a
//                saturating trim term, splits it across two PWM duties and
//                requests a position-counter clear at the start of every run.
//  Revision    : 1.0  initial release
// ============================================================================
module motor_balance_ctrl
    import motor_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int UPDATE_CYCLES = 100000,
    parameter int DEADBAND      = 2,
    parameter int TRIM_STEP     = 1,
    parameter int MAX_TRIM      = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] base_duty,
    input  logic [15:0]         pos_diff,
    output logic [1:0]          clear,
    output logic                pwm1,
    output logic                pwm2,
    output logic [PWM_BITS-1:0] duty1,
    output logic [PWM_BITS-1:0] duty2,
    output logic [7:0]          trim,
    output logic                update
);

    localparam int                  c_INTV_W    = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam int                  c_AW        = PWM_BITS + 2;
    localparam int                  c_DUTY_MAX  = (1 << PWM_BITS) - 1;
    localparam logic [c_INTV_W-1:0] c_INTV_LAST = c_INTV_W'(UPDATE_CYCLES - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [c_INTV_W-1:0]         r_intv;
    logic [PWM_BITS-1:0]         r_pc;
    logic signed [PWM_BITS-1:0]  r_trim;

    int                          w_pd;
    int                          w_trim_cur;
    int                          w_trim_nxt;

    logic signed [PWM_BITS-1:0]  w_trim_eff;
    logic signed [c_AW-1:0]      w_base_x;
    logic signed [c_AW-1:0]      w_trim_x;
    logic signed [c_AW-1:0]      w_sum1;
    logic signed [c_AW-1:0]      w_sum2;
    logic [PWM_BITS-1:0]         w_t1;
    logic [PWM_BITS-1:0]         w_t2;
    logic                        w_load;
    logic                        w_stop;

    // State register; reset aborts any run immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic with Moore-style clear/update strobes
    always_comb begin
        w_next = r_state;
        clear  = 2'b00;
        update = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear  = c_CLEAR_ALL;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    w_next = ST_IDLE;
                end else if (r_intv == c_INTV_LAST) begin
                    w_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                update = 1'b1;
                w_next = enable ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Update interval counter runs only while waiting in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_intv <= '0;
        end else if (r_state == ST_RUN) begin
            r_intv <= r_intv + c_INTV_W'(1);
        end else begin
            r_intv <= '0;
        end
    end

    // Shared PWM period counter; parked at zero in IDLE and CLEAR so the first
    // period after CLEAR starts cleanly with the freshly loaded duty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (r_state == ST_IDLE || r_state == ST_CLEAR) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + PWM_BITS'(1);
        end
    end

    assign w_pd       = int'($signed(pos_diff));
    assign w_trim_cur = int'(r_trim);

    // Deadband decision and saturating step for the next trim value
    always_comb begin
        w_trim_nxt = w_trim_cur;
        if (w_pd > DEADBAND) begin
            w_trim_nxt = sat(w_trim_cur + TRIM_STEP, -MAX_TRIM, MAX_TRIM);
        end else if (w_pd < -DEADBAND) begin
            w_trim_nxt = sat(w_trim_cur - TRIM_STEP, -MAX_TRIM, MAX_TRIM);
        end
    end

    // Trim register: zeroed at run start, stepped on UPDATE, otherwise retained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trim <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_trim <= '0;
        end else if (r_state == ST_UPDATE) begin
            r_trim <= PWM_BITS'(w_trim_nxt);
        end
    end

    assign trim = 8'(w_trim_cur);

    // Duty load in CLEAR must already see the zeroed trim, not the previous run's
    assign w_trim_eff = (r_state == ST_CLEAR) ? '0 : r_trim;
    assign w_base_x   = $signed({2'b00, base_duty});
    assign w_trim_x   = {{2{w_trim_eff[PWM_BITS-1]}}, w_trim_eff};
    assign w_sum1     = w_base_x - w_trim_x;
    assign w_sum2     = w_base_x + w_trim_x;
    assign w_t1       = PWM_BITS'(sat(int'(w_sum1), 0, c_DUTY_MAX));
    assign w_t2       = PWM_BITS'(sat(int'(w_sum2), 0, c_DUTY_MAX));

    // Load on the edge where the counter returns to zero, or on run start
    assign w_load = (r_state == ST_CLEAR) ||
                    (((r_state == ST_RUN) || (r_state == ST_UPDATE)) && (r_pc == '1));
    // Drop both channels on the same edge the FSM falls back to IDLE
    assign w_stop = (w_next == ST_IDLE);

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm1 (
        .clk      (clk),
        .rst      (reset),
        .i_stop   (w_stop),
        .i_load   (w_load),
        .i_target (w_t1),
        .i_pc     (r_pc),
        .o_duty   (duty1),
        .o_pwm    (pwm1)
    );

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm2 (
        .clk      (clk),
        .rst      (reset),
        .i_stop   (w_stop),
        .i_load   (w_load),
        .i_target (w_t2),
        .i_pc     (r_pc),
        .o_duty   (duty2),
        .o_pwm    (pwm2)
    );

endmodule
`default_nettype wire

// File: tb/tb_motor_balance_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_balance_ctrl
//  Description : Self-checking bench for motor_balance_ctrl with a trim/duty
//                reference model driven by directed and random pos_diff values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_motor_balance_ctrl;

    localparam int PWM_BITS      = 8;
    localparam int UPDATE_CYCLES = 8;
    localparam int DEADBAND      = 2;
    localparam int TRIM_STEP     = 1;
    localparam int MAX_TRIM      = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  base_duty;
    logic [15:0] pos_diff;
    logic [1:0]  clear;
    logic        pwm1;
    logic        pwm2;
    logic [7:0]  duty1;
    logic [7:0]  duty2;
    logic [7:0]  trim;
    logic        update;

    int n_pass  = 0;
    int n_total = 0;
    int model_trim = 0;
    int model_base = 128;

    motor_balance_ctrl #(
        .PWM_BITS      (PWM_BITS),
        .UPDATE_CYCLES (UPDATE_CYCLES),
        .DEADBAND      (DEADBAND),
        .TRIM_STEP     (TRIM_STEP),
        .MAX_TRIM      (MAX_TRIM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .base_duty (base_duty),
        .pos_diff  (pos_diff),
        .clear     (clear),
        .pwm1      (pwm1),
        .pwm2      (pwm2),
        .duty1     (duty1),
        .duty2     (duty2),
        .trim      (trim),
        .update    (update)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: duty = base -/+ trim limited to the 0..255 duty range
    function automatic int model_duty(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference: one trim evaluation from the current signed position difference
    task automatic model_step();
        int pd;
        pd = int'($signed(pos_diff));
        if (pd > DEADBAND) begin
            model_trim = model_trim + TRIM_STEP;
            if (model_trim > MAX_TRIM) model_trim = MAX_TRIM;
        end else if (pd < -DEADBAND) begin
            model_trim = model_trim - TRIM_STEP;
            if (model_trim < -MAX_TRIM) model_trim = -MAX_TRIM;
        end
    endtask

    task automatic check_trim(input string tag);
        logic [31:0] e;
        e = model_trim & 32'hFF;
        check(tag, {24'b0, trim}, e);
    endtask

    task automatic set_base(input int b);
        model_base = b;
        base_duty  = 8'(b);
    endtask

    // Wait (bounded) for the next update pulse, step the model, verify trim
    task automatic wait_update();
        int n;
        n = 0;
        while (update !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("update_seen", {31'b0, update}, 32'd1);
        model_step();
        @(negedge clk);
        check("update_one_cycle", {31'b0, update}, 32'd0);
        check_trim("trim_after_update");
    endtask

    // Hold trim (deadband) long enough for at least one PWM wrap
    task automatic settle();
        pos_diff = 16'd0;
        repeat (260) @(negedge clk);
    endtask

    task automatic check_duties();
        check("duty1", {24'b0, duty1}, 32'(model_duty(model_base - model_trim)));
        check("duty2", {24'b0, duty2}, 32'(model_duty(model_base + model_trim)));
    endtask

    task automatic check_pwm_counts();
        int c1;
        int c2;
        c1 = 0;
        c2 = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm1 === 1'b1) c1++;
            if (pwm2 === 1'b1) c2++;
        end
        check("pwm1_high_count", 32'(c1), 32'(model_duty(model_base - model_trim)));
        check("pwm2_high_count", 32'(c2), 32'(model_duty(model_base + model_trim)));
    endtask

    // Raise enable and expect exactly one 2'b11 clear cycle, trim back to zero
    task automatic start_run();
        int n11;
        int nbad;
        n11  = 0;
        nbad = 0;
        enable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (clear === 2'b11) n11++;
            else if (clear !== 2'b00) nbad++;
        end
        model_trim = 0;
        check("clear_pulse_cycles", 32'(n11), 32'd1);
        check("clear_bad_values", 32'(nbad), 32'd0);
        check_trim("trim_after_clear");
        check_duties();
    endtask

    initial begin
        int n;
        int cnt;
        int quiet;
        bit found;
        bit stable;
        logic prev;

        reset     = 1'b1;
        enable    = 1'b0;
        base_duty = 8'd128;
        pos_diff  = 16'd0;
        repeat (3) @(negedge clk);

        check("rst_clear",  {30'b0, clear}, 32'd0);
        check("rst_pwm1",   {31'b0, pwm1}, 32'd0);
        check("rst_pwm2",   {31'b0, pwm2}, 32'd0);
        check("rst_duty1",  {24'b0, duty1}, 32'd0);
        check("rst_duty2",  {24'b0, duty2}, 32'd0);
        check("rst_trim",   {24'b0, trim}, 32'd0);
        check("rst_update", {31'b0, update}, 32'd0);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_clear", {30'b0, clear}, 32'd0);

        // Run start: clear pulse, duties at base
        set_base(128);
        start_run();
        check("start_duty1_128", {24'b0, duty1}, 32'd128);

        // Three positive updates, then duty at next wrap and pwm widths
        pos_diff = 16'd10;
        repeat (3) wait_update();
        check("trim_is_3", {24'b0, trim}, 32'd3);
        settle();
        check_duties();
        check_pwm_counts();

        // Deadband edges and a negative two's-complement input
        pos_diff = 16'd2;      wait_update();
        pos_diff = 16'hFFFE;   wait_update();
        pos_diff = 16'd3;      wait_update();
        pos_diff = 16'hFFFD;   wait_update();
        pos_diff = 16'hFFF0;   wait_update();

        // Random pos_diff sequence against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       pos_diff = 16'($urandom);
                1:       pos_diff = 16'($signed($urandom_range(0, 8)) - 4);
                default: pos_diff = ($urandom_range(0, 1) == 0) ? 16'd300 : 16'hFED4;
            endcase
            wait_update();
        end
        set_base(int'($urandom_range(0, 255)));
        settle();
        check_duties();
        check_pwm_counts();

        // Negative saturation with high base: duty1 clamps at top
        set_base(250);
        pos_diff = 16'hFF9C;
        repeat (130) wait_update();
        check("trim_neg_sat", {24'b0, trim}, 32'hC0);
        settle();
        check_duties();
        check("duty1_clamped_255", {24'b0, duty1}, 32'd255);
        check_pwm_counts();

        // Positive saturation with low base: duty1 clamps at zero
        pos_diff = 16'd100;
        repeat (130) wait_update();
        check("trim_pos_sat", {24'b0, trim}, 32'd64);
        set_base(10);
        settle();
        check_duties();
        check_pwm_counts();

        // Mid-period base change must not disturb the running period
        set_base(128);
        settle();
        check_duties();
        found = 1'b0;
        n = 0;
        prev = pwm1;
        while (!found && n < 300) begin
            @(negedge clk);
            n++;
            if (prev === 1'b0 && pwm1 === 1'b1) found = 1'b1;
            prev = pwm1;
        end
        check("pwm1_rise_found", {31'b0, found}, 32'd1);
        set_base(100);
        stable = 1'b1;
        cnt = (pwm1 === 1'b1) ? 1 : 0;
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            if (i < 250 && duty1 !== 8'd64) stable = 1'b0;
            if (pwm1 === 1'b1) cnt++;
        end
        check("duty1_stable_mid_period", {31'b0, stable}, 32'd1);
        check("pwm1_old_period_width", 32'(cnt), 32'd64);
        repeat (2) @(negedge clk);
        check_duties();

        // Disable: outputs low on the next edge, trim retained
        enable = 1'b0;
        @(negedge clk);
        check("dis_pwm1",  {31'b0, pwm1}, 32'd0);
        check("dis_pwm2",  {31'b0, pwm2}, 32'd0);
        check("dis_duty1", {24'b0, duty1}, 32'd0);
        check("dis_duty2", {24'b0, duty2}, 32'd0);
        check_trim("dis_trim_retained");
        repeat (3) @(negedge clk);
        start_run();

        // Async reset mid-run with trim 5
        pos_diff = 16'd10;
        repeat (5) wait_update();
        check("trim_is_5", {24'b0, trim}, 32'd5);
        #3;
        reset = 1'b1;
        #1;
        model_trim = 0;
        check("arst_trim",  {24'b0, trim}, 32'd0);
        check("arst_pwm1",  {31'b0, pwm1}, 32'd0);
        check("arst_pwm2",  {31'b0, pwm2}, 32'd0);
        check("arst_duty1", {24'b0, duty1}, 32'd0);
        check("arst_clear", {30'b0, clear}, 32'd0);
        @(negedge clk);
        enable   = 1'b0;
        pos_diff = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (clear !== 2'b00 || update !== 1'b0) quiet++;
        end
        check("no_clear_after_reset", 32'(quiet), 32'd0);
        start_run();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
